// File: rtl/vec_mul_pkg.sv
// Shared widths, drain FSM encoding and the per-lane requantizer used by the
// result path of the vector-multiply engine.
package vec_mul_pkg;

  localparam int PARTIAL_SUM_BW = 20;
  localparam int OUT_BW         = 8;
  localparam int MATRIX_SIZE    = 8;
  localparam int SHIFT_BW       = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

  // Saturation limits held at the widened (PARTIAL_SUM_BW+1) precision.
  localparam logic signed [PARTIAL_SUM_BW:0] SAT_MAX =
    (PARTIAL_SUM_BW+1)'(2**(OUT_BW-1) - 1);
  localparam logic signed [PARTIAL_SUM_BW:0] SAT_MIN =
    (PARTIAL_SUM_BW+1)'(-(2**(OUT_BW-1)));

  // ReLU, round-half-up arithmetic shift, then saturate to OUT_BW signed.
  function automatic logic [OUT_BW-1:0] requant_lane(
    input logic [PARTIAL_SUM_BW-1:0] x,
    input logic [SHIFT_BW-1:0]       shift,
    input logic                      relu
  );
    logic signed [PARTIAL_SUM_BW:0] v;
    logic signed [PARTIAL_SUM_BW:0] rnd;
    v   = {x[PARTIAL_SUM_BW-1], x};
    rnd = '0;
    if (relu && v[PARTIAL_SUM_BW]) begin
      v = '0;
    end
    if (shift != '0) begin
      rnd = (PARTIAL_SUM_BW+1)'(1) << (shift - SHIFT_BW'(1));
      v   = (v + rnd) >>> shift;
    end
    if (v > SAT_MAX) begin
      v = SAT_MAX;
    end else if (v < SAT_MIN) begin
      v = SAT_MIN;
    end
    return v[OUT_BW-1:0];
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Row stream leaving the result drain: one requantized row per transfer.
interface result_drain_if #(
    parameter int DATA_W = 64
);
    // A row moves on every cycle where out_valid && out_ready. Once out_valid
    // rises it stays high, with out_data/out_last frozen, until that transfer.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry buffer between the SRAM read return and the output stream;
// a push and a pop in the same cycle are both honoured.
module result_skid_fifo #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (occupancy != 2'd0);
    assign do_push   = push && ((occupancy != 2'd2) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/result_drain.sv
// Drains MATRIX_SIZE result rows from the result SRAM after a compute-done
// pulse, requantizes every lane to OUT_BW signed and streams rows out.
module result_drain #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int OUT_BW         = 8,
    parameter int SHIFT_BW       = 5
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                end_,
    input  logic [SHIFT_BW-1:0]                 shift,
    input  logic                                relu_en,
    output logic                                sram_result_read_en,
    output logic [ADDRESSSIZE-1:0]              sram_result_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_result_data_out,
    result_drain_if.master                      res,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          dbg_state
);
    import vec_mul_pkg::*;

    localparam int ROW_W = OUT_BW*MATRIX_SIZE + 1;

    drain_state_t                 state;
    logic [SHIFT_BW-1:0]          shift_q;
    logic                         relu_q;
    logic [ADDRESSSIZE-1:0]       addr_q;
    logic                         rd_pending;
    logic                         rd_pending_last;
    logic [1:0]                   occupancy;
    logic [ROW_W-1:0]             head_data;
    logic [OUT_BW*MATRIX_SIZE-1:0] q_row;
    logic                         pop;
    logic                         issue;
    logic [2:0]                   inflight;

    // A slot is free when reads in flight plus buffered rows, minus the row
    // leaving this cycle, leave room; counting the pop keeps full throughput.
    assign pop      = res.out_valid && res.out_ready;
    assign inflight = 3'(occupancy) + 3'(rd_pending) - 3'(pop);
    assign issue    = (state == ST_READ) && (inflight < 3'd2);

    assign sram_result_read_en = issue;
    assign sram_result_address = addr_q;
    assign dbg_state           = state;

    for (genvar l = 0; l < MATRIX_SIZE; l++) begin : g_lane
        assign q_row[l*OUT_BW +: OUT_BW] =
            requant_lane(sram_result_data_out[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW],
                         shift_q, relu_q);
    end

    result_skid_fifo #(
        .WIDTH (ROW_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rd_pending),
        .push_data ({rd_pending_last, q_row}),
        .pop       (pop),
        .head_data (head_data),
        .occupancy (occupancy)
    );

    assign res.out_valid = (occupancy != 2'd0);
    assign res.out_last  = head_data[ROW_W-1];
    assign res.out_data  = head_data[ROW_W-2:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            addr_q          <= '0;
            shift_q         <= '0;
            relu_q          <= 1'b0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
        end else begin
            done            <= 1'b0;
            rd_pending      <= issue;
            rd_pending_last <= issue && (addr_q == ADDRESSSIZE'(MATRIX_SIZE-1));
            case (state)
                ST_IDLE: begin
                    if (end_) begin
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        addr_q  <= '0;
                        busy    <= 1'b1;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q <= addr_q + ADDRESSSIZE'(1);
                        if (addr_q == ADDRESSSIZE'(MATRIX_SIZE-1)) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The last row is always the final buffered entry.
                    if (pop && res.out_last) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain: SRAM model, ready driver, and a
// scoreboard fed from an arithmetic requantization model.
module tb_result_drain;
    import vec_mul_pkg::*;

    localparam int MS    = MATRIX_SIZE;
    localparam int PSB   = PARTIAL_SUM_BW;
    localparam int OB    = OUT_BW;
    localparam int ROW_W = OB*MS + 1;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                end_ = 1'b0;
    logic                relu_en = 1'b0;
    logic [SHIFT_BW-1:0] shift = '0;
    logic                sram_result_read_en;
    logic [9:0]          sram_result_address;
    logic [PSB*MS-1:0]   sram_result_data_out = '0;
    logic                busy;
    logic                done;
    logic [1:0]          dbg_state;

    result_drain_if #(.DATA_W(OB*MS)) bus ();

    result_drain dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .end_                 (end_),
        .shift                (shift),
        .relu_en              (relu_en),
        .sram_result_read_en  (sram_result_read_en),
        .sram_result_address  (sram_result_address),
        .sram_result_data_out (sram_result_data_out),
        .res                  (bus),
        .busy                 (busy),
        .done                 (done),
        .dbg_state            (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model (1-cycle read latency) ----------------
    logic [PSB*MS-1:0] mem [MS];
    always @(posedge clk) begin
        if (sram_result_read_en && (sram_result_address < 10'(MS)))
            sram_result_data_out <= mem[sram_result_address[2:0]];
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] got[$];
    int xfer_cyc[$];
    int done_cyc[$];
    int issued = 0;
    int popped = 0;
    int k_edge = 0;
    int ready_mode = 0;
    bit prev_stall = 1'b0;
    logic [ROW_W-1:0] prev_row = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [OB-1:0] ref_lane(input logic [PSB-1:0] raw, input int sh, input bit relu);
        logic signed [PSB-1:0] sraw;
        int v, d, num;
        sraw = raw;
        v = sraw;
        if (relu && v < 0) v = 0;
        if (sh > 0) begin
            d   = 1 << sh;
            num = v + d / 2;
            if (num >= 0) v = num / d;
            else          v = -((-num + d - 1) / d);
        end
        if (v > 2**(OB-1) - 1) v = 2**(OB-1) - 1;
        if (v < -(2**(OB-1)))  v = -(2**(OB-1));
        return v[OB-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] ref_row(input int r, input int sh, input bit relu);
        logic [ROW_W-1:0] row;
        for (int l = 0; l < MS; l++)
            row[l*OB +: OB] = ref_lane(mem[r][l*PSB +: PSB], sh, relu);
        row[ROW_W-1] = (r == MS - 1);
        return row;
    endfunction

    function automatic logic [OB-1:0] lane_of(input logic [ROW_W-1:0] row, input int l);
        return row[l*OB +: OB];
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [ROW_W-1:0] row;
        row = {bus.out_last, bus.out_data};
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 128'(bus.out_valid), 128'(1));
                check("stall_row", 128'(row), 128'(prev_row));
            end
            if (sram_result_read_en) issued++;
            if (bus.out_valid && bus.out_ready) begin
                popped++;
                xfer_cyc.push_back(cyc + 1);
                got.push_back(row);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_row: got %0h, required no row", row);
                end else begin
                    check("row", 128'(row), 128'(exp_q.pop_front()));
                end
            end
            if (sram_result_read_en)
                check("inflight_le_2", 128'(issued - popped <= 2), 128'(1));
            if (done) done_cyc.push_back(cyc + 1);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_row   = row;
        end
    end

    // ---------------- ready driver ----------------
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic fill_random();
        for (int r = 0; r < MS; r++)
            for (int l = 0; l < MS; l++)
                mem[r][l*PSB +: PSB] = PSB'($urandom);
    endtask

    task automatic start_drain(input int sh, input bit relu);
        xfer_cyc.delete();
        done_cyc.delete();
        got.delete();
        for (int r = 0; r < MS; r++) exp_q.push_back(ref_row(r, sh, relu));
        @(posedge clk); #1;
        shift   = SHIFT_BW'(sh);
        relu_en = relu;
        end_    = 1'b1;
        k_edge  = cyc + 1;
        @(posedge clk); #1;
        end_ = 1'b0;
        check("busy_k1", 128'(busy), 128'(1));
        check("read_en_k1", 128'(sram_result_read_en), 128'(1));
        check("addr_k1", 128'(sram_result_address), 128'(0));
    endtask

    task automatic wait_rows(input int n);
        int t = 0;
        while (got.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (got.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL rows_timeout: got %0d rows, required %0d", got.size(), n);
        end
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (done_cyc.size() == 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (done_cyc.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, required done within 400 cycles", tag);
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_rows"}, 128'(got.size()), 128'(MS));
        check({tag, "_exp_left"}, 128'(exp_q.size()), 128'(0));
        check({tag, "_done_cnt"}, 128'(done_cyc.size()), 128'(1));
        check({tag, "_busy_idle"}, 128'(busy), 128'(0));
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read_en"}, 128'(sram_result_read_en), 128'(0));
        check({tag, "_addr"}, 128'(sram_result_address), 128'(0));
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_data"}, 128'(bus.out_data), 128'(0));
        check({tag, "_last"}, 128'(bus.out_last), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_state"}, 128'(dbg_state), 128'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int sh;
        bit rl;
        bus.out_ready = 1'b1;
        for (int r = 0; r < MS; r++) mem[r] = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        // Full throughput: lane value r*16+l, ready held high.
        ready_mode = 0;
        for (int r = 0; r < MS; r++)
            for (int l = 0; l < MS; l++)
                mem[r][l*PSB +: PSB] = PSB'(r*16 + l);
        start_drain(0, 1'b0);
        wait_drain("full");
        for (int i = 0; i < MS; i++)
            if (i < xfer_cyc.size()) check("full_xfer_cycle", 128'(xfer_cyc[i]), 128'(k_edge + 3 + i));
        if (done_cyc.size() > 0) check("full_done_cycle", 128'(done_cyc[0]), 128'(k_edge + 11));
        if (got.size() == MS) check("full_r7_l7", 128'(lane_of(got[7], 7)), 128'(8'h77));

        // ReLU and saturation corners in lanes 0..2 of every row.
        fill_random();
        for (int r = 0; r < MS; r++) begin
            mem[r][0*PSB +: PSB] = PSB'(-5);
            mem[r][1*PSB +: PSB] = 20'h7FFFF;
            mem[r][2*PSB +: PSB] = 20'h80000;
        end
        start_drain(0, 1'b0);
        wait_drain("sat");
        if (got.size() == MS) begin
            check("sat_neg5", 128'(lane_of(got[0], 0)), 128'(8'hFB));
            check("sat_max", 128'(lane_of(got[0], 1)), 128'(8'h7F));
            check("sat_min", 128'(lane_of(got[0], 2)), 128'(8'h80));
        end
        start_drain(0, 1'b1);
        wait_drain("relu");
        if (got.size() == MS) begin
            check("relu_neg5", 128'(lane_of(got[0], 0)), 128'(8'h00));
            check("relu_max", 128'(lane_of(got[0], 1)), 128'(8'h7F));
            check("relu_min", 128'(lane_of(got[0], 2)), 128'(8'h00));
        end

        // Rounding shift of 2.
        fill_random();
        for (int r = 0; r < MS; r++) begin
            mem[r][0*PSB +: PSB] = PSB'(23);
            mem[r][1*PSB +: PSB] = PSB'(-23);
            mem[r][2*PSB +: PSB] = PSB'(2);
        end
        start_drain(2, 1'b0);
        wait_drain("shift");
        if (got.size() == MS) begin
            check("shift_23", 128'(lane_of(got[3], 0)), 128'(8'h06));
            check("shift_m23", 128'(lane_of(got[3], 1)), 128'(8'hFA));
            check("shift_2", 128'(lane_of(got[3], 2)), 128'(8'h01));
        end

        // Backpressure: toggling ready, then a 5-cycle stall.
        fill_random();
        ready_mode = 1;
        start_drain($urandom_range(0, PSB-1), 1'($urandom_range(0, 1)));
        wait_rows(4);
        ready_mode = 3;
        repeat (5) @(posedge clk);
        ready_mode = 0;
        wait_drain("bp");

        // Re-trigger while busy is ignored.
        fill_random();
        ready_mode = 2;
        start_drain($urandom_range(0, PSB-1), 1'b0);
        wait_rows(3);
        @(posedge clk); #1;
        end_  = 1'b1;
        shift = SHIFT_BW'(7);
        @(posedge clk); #1;
        end_ = 1'b0;
        wait_drain("retrig");
        repeat (20) @(posedge clk);
        check("retrig_no_extra_rows", 128'(got.size()), 128'(MS));
        check("retrig_no_extra_done", 128'(done_cyc.size()), 128'(1));

        // Reset mid-drain, then restart from address 0.
        fill_random();
        ready_mode = 0;
        start_drain($urandom_range(0, PSB-1), 1'($urandom_range(0, 1)));
        wait_rows(4);
        @(posedge clk); #1;
        ready_mode = 3;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_q.delete();
        issued = 0;
        popped = 0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        ready_mode = 0;
        start_drain($urandom_range(0, PSB-1), 1'($urandom_range(0, 1)));
        wait_drain("restart");

        // Random drains with random ready.
        for (int n = 0; n < 4; n++) begin
            fill_random();
            ready_mode = 2;
            sh = $urandom_range(0, PSB-1);
            rl = 1'($urandom_range(0, 1));
            start_drain(sh, rl);
            wait_drain("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
